hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Pipeline sequencing controller for the 5-stage core, sitting beside the forwarding logic in the ID/EX boundary. It detects the hazards forwarding cannot cover and drives the pipeline-register enables, flush and bubble controls:
- load-use stalls
- taken-branch flushes
- multi-cycle EX operations (mul/div) that must hold the EX stage for a fixed number of cycles

It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MC_CYCLES, 4, total EX-stage occupancy of a multi-cycle op in cycles; legal range 2..255
- CNT_W, 16, width of stall_count

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_op1  in  4  first source register of the instruction in ID
- id_op2  in  4  second source register of the instruction in ID
- id_uses_op2  in  1  instruction in ID actually reads id_op2
- idex_memread  in  1  instruction in ID/EX is a load
- idex_rd  in  4  destination register of the instruction in ID/EX
- idex_mc  in  1  instruction in ID/EX is a multi-cycle op
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX instead of the decoded instruction
- ex_hold  out  1  hold ID/EX and the EX stage (multi-cycle op in progress)
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- FSM states: RUN, LDSTALL, MCBUSY.
- Down-counter mc_cnt is 8 bits.
- All control outputs are combinational from state and inputs (Mealy).
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, ex_hold=0.

RUN, evaluated in priority order:
1. ex_branch_taken=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Next state is RUN. idex_mc and load-use are ignored this cycle.
2. idex_mc=1 -> pc_write=0, ifid_write=0, ex_hold=1. Next state is MCBUSY, mc_cnt <= MC_CYCLES-2.
3. Load-use: idex_memread=1 and idex_rd!=0 and (idex_rd==id_op1 or (id_uses_op2 and idex_rd==id_op2)). Response: pc_write=0, ifid_write=0, idex_bubble=1. Next state is LDSTALL.
4. Otherwise, default outputs and stay in RUN.

LDSTALL:
- Default outputs.
- Load-use detection and idex_mc are suppressed.
- Next state is RUN unconditionally.

MCBUSY:
- idex_mc, ex_branch_taken and load-use inputs are ignored.
- mc_cnt!=0 -> pc_write=0, ifid_write=0, ex_hold=1, mc_cnt <= mc_cnt-1.
- mc_cnt==0 -> default outputs (the op retires and ID/EX advances). Next state is RUN.

stall_count:
- Increments at each rising edge where pc_write=0.
- Saturates at all-ones and never wraps.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, mc_cnt=0, stall_count=0.
- Outputs during reset follow RUN decoding. With all inputs 0: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, ex_hold=0.
- Reset asserted mid-MCBUSY or mid-LDSTALL aborts immediately; there is no pending stall after release.
- Load-use stall is exactly 1 cycle; stall_count +1.
- A multi-cycle op stalls fetch/decode for MC_CYCLES-1 consecutive cycles: the detect cycle plus MC_CYCLES-2 MCBUSY cycles. EX occupancy is MC_CYCLES cycles and stall_count increases by MC_CYCLES-1.
- MC_CYCLES=2: MCBUSY is entered with mc_cnt=0, so only the detect cycle stalls.
- Branch flush costs 0 stall cycles, 2 squashed instructions, and no stall_count change.
- idex_rd==0 never causes a stall (r0 is constant).
- The counter must not increment on the release cycle.

## Test plan
- Reset: drive MC_CYCLES=4 op, assert rst_n=0 in the 2nd MCBUSY cycle -> ex_hold=0 and pc_write=1 immediately (before the clock edge), stall_count=0; after release with idle inputs, no stall.
- Load-use: idex_memread=1, idex_rd=5, id_op1=5 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle with idex_memread=0 -> pc_write=1; stall_count=1.
- Load-use exceptions, each giving no stall: idex_rd=0 with id_op1=0; idex_rd=7 with id_op2=7 and id_uses_op2=0. Control: id_uses_op2=1 gives a 1-cycle stall.
- Multi-cycle: MC_CYCLES=4, idex_mc=1 held -> ex_hold=1 and pc_write=0 for exactly 3 cycles, released on the 4th; stall_count +3. Repeat with MC_CYCLES=2 -> 1 stall cycle.
- Simultaneous events: ex_branch_taken=1 with a matching load-use and idex_mc=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, ex_hold=0, state stays RUN, stall_count unchanged.
- Saturation: CNT_W=4, issue 20 load-use stalls -> stall_count stops at 15 and does not wrap.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall control bundle between the pipeline datapath and the
// sequencing controller: hazard sources in, stage enables/flush controls out.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_op1;
  logic [3:0]       id_op2;
  logic             id_uses_op2;
  logic             idex_memread;
  logic [3:0]       idex_rd;
  logic             idex_mc;
  logic             ex_branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             ex_hold;
  logic [CNT_W-1:0] stall_count;

  // Datapath side: supplies hazard information, consumes controls.
  modport master (
    output id_op1, id_op2, id_uses_op2, idex_memread, idex_rd, idex_mc,
           ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, stall_count
  );

  // Controller side.
  modport slave (
    input  id_op1, id_op2, id_uses_op2, idex_memread, idex_rd, idex_mc,
           ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// multi-cycle EX holds, and a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hazard_stall_controller_if.slave   bus
);

  typedef enum logic [1:0] {RUN, LDSTALL, MCBUSY} state_t;

  // The detect cycle is one stall, so MCBUSY only has to cover the rest.
  localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 2);

  state_t           state_reg, state_next;
  logic [7:0]       mc_cnt_reg, mc_cnt_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             load_use;

  // r0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign load_use = bus.idex_memread && (bus.idex_rd != 4'd0) &&
                    ((bus.idex_rd == bus.id_op1) ||
                     (bus.id_uses_op2 && (bus.idex_rd == bus.id_op2)));

  // State and multi-cycle down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      mc_cnt_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
    end
  end

  // Next-state decode; a taken branch outranks everything in RUN.
  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;
    unique case (state_reg)
      RUN: begin
        if (bus.ex_branch_taken) begin
          state_next = RUN;
        end else if (bus.idex_mc) begin
          state_next  = MCBUSY;
          mc_cnt_next = MC_LOAD;
        end else if (load_use) begin
          state_next = LDSTALL;
        end
      end
      LDSTALL: state_next = RUN;
      MCBUSY: begin
        if (mc_cnt_reg != 8'd0) begin
          mc_cnt_next = mc_cnt_reg - 8'd1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Mealy output decode for the stage enables and flush/bubble controls.
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.ex_hold     = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (bus.ex_branch_taken) begin
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
        end else if (bus.idex_mc) begin
          bus.pc_write   = 1'b0;
          bus.ifid_write = 1'b0;
          bus.ex_hold    = 1'b1;
        end else if (load_use) begin
          bus.pc_write    = 1'b0;
          bus.ifid_write  = 1'b0;
          bus.idex_bubble = 1'b1;
        end
      end
      LDSTALL: ;
      MCBUSY: begin
        if (mc_cnt_reg != 8'd0) begin
          bus.pc_write   = 1'b0;
          bus.ifid_write = 1'b0;
          bus.ex_hold    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Saturating count of cycles in which the PC was frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!bus.pc_write && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.stall_count = cnt_reg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three configurations (MC_CYCLES=4 /
// CNT_W=16, MC_CYCLES=2, CNT_W=4) share one stimulus bus; each sequence
// checks one of them through an expected-value queue.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] in_op1 = '0, in_op2 = '0, in_rd = '0;
  logic       in_uses2 = 1'b0, in_mem = 1'b0, in_mc = 1'b0, in_br = 1'b0;

  hazard_stall_controller_if #(.CNT_W(16)) ifa ();
  hazard_stall_controller_if #(.CNT_W(16)) ifb ();
  hazard_stall_controller_if #(.CNT_W(4))  ifc ();

  hazard_stall_controller #(.MC_CYCLES(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  hazard_stall_controller #(.MC_CYCLES(2), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  hazard_stall_controller #(.MC_CYCLES(4), .CNT_W(4))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  assign ifa.id_op1 = in_op1;  assign ifb.id_op1 = in_op1;  assign ifc.id_op1 = in_op1;
  assign ifa.id_op2 = in_op2;  assign ifb.id_op2 = in_op2;  assign ifc.id_op2 = in_op2;
  assign ifa.id_uses_op2 = in_uses2;  assign ifb.id_uses_op2 = in_uses2;  assign ifc.id_uses_op2 = in_uses2;
  assign ifa.idex_memread = in_mem;   assign ifb.idex_memread = in_mem;   assign ifc.idex_memread = in_mem;
  assign ifa.idex_rd = in_rd;  assign ifb.idex_rd = in_rd;  assign ifc.idex_rd = in_rd;
  assign ifa.idex_mc = in_mc;  assign ifb.idex_mc = in_mc;  assign ifc.idex_mc = in_mc;
  assign ifa.ex_branch_taken = in_br;  assign ifb.ex_branch_taken = in_br;  assign ifc.ex_branch_taken = in_br;

  logic pw[3], iw[3], fl[3], bb[3], hd[3];
  int   cnt[3];
  assign pw[0] = ifa.pc_write;    assign pw[1] = ifb.pc_write;    assign pw[2] = ifc.pc_write;
  assign iw[0] = ifa.ifid_write;  assign iw[1] = ifb.ifid_write;  assign iw[2] = ifc.ifid_write;
  assign fl[0] = ifa.ifid_flush;  assign fl[1] = ifb.ifid_flush;  assign fl[2] = ifc.ifid_flush;
  assign bb[0] = ifa.idex_bubble; assign bb[1] = ifb.idex_bubble; assign bb[2] = ifc.idex_bubble;
  assign hd[0] = ifa.ex_hold;     assign hd[1] = ifb.ex_hold;     assign hd[2] = ifc.ex_hold;
  assign cnt[0] = int'(ifa.stall_count);
  assign cnt[1] = int'(ifb.stall_count);
  assign cnt[2] = int'(ifc.stall_count);

  typedef struct {
    logic [3:0] op1, op2, rd;
    logic       uses2, mem, mc, br;
  } stim_t;

  typedef struct {
    logic pw, iw, fl, bb, hd;
    int   cnt;
  } out_t;

  typedef struct {
    stim_t s;
    out_t  e;
  } vec_t;

  typedef struct {
    int    sel;
    string tag;
    out_t  e;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic stim_t mk_s(int op1, int op2, int uses2, int mem, int rd, int mc, int br);
    stim_t s;
    s.op1 = 4'(op1); s.op2 = 4'(op2); s.uses2 = 1'(uses2); s.mem = 1'(mem);
    s.rd = 4'(rd);   s.mc = 1'(mc);   s.br = 1'(br);
    return s;
  endfunction

  function automatic out_t mk_e(int p, int i, int f, int b, int h, int c);
    out_t e;
    e.pw = 1'(p); e.iw = 1'(i); e.fl = 1'(f); e.bb = 1'(b); e.hd = 1'(h); e.cnt = c;
    return e;
  endfunction

  task automatic chk(string tag, string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, nm, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the selected DUT.
  task automatic check_now();
    exp_t x;
    int   s;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: queue empty at t=%0t", $time);
      return;
    end
    x = sb_q.pop_front();
    s = x.sel;
    chk(x.tag, "pc_write",    int'(pw[s]), int'(x.e.pw));
    chk(x.tag, "ifid_write",  int'(iw[s]), int'(x.e.iw));
    chk(x.tag, "ifid_flush",  int'(fl[s]), int'(x.e.fl));
    chk(x.tag, "idex_bubble", int'(bb[s]), int'(x.e.bb));
    chk(x.tag, "ex_hold",     int'(hd[s]), int'(x.e.hd));
    chk(x.tag, "stall_count", cnt[s],      x.e.cnt);
    $display("txn %-10s dut%0d pw=%0d iw=%0d fl=%0d bb=%0d hd=%0d cnt=%0d", x.tag, s,
             pw[s], iw[s], fl[s], bb[s], hd[s], cnt[s]);
  endtask

  task automatic push_exp(int sel, string tag, out_t e);
    exp_t x;
    x.sel = sel; x.tag = tag; x.e = e;
    sb_q.push_back(x);
  endtask

  // One cycle: drive at the falling edge, check before the next rising edge.
  task automatic step(stim_t s, int sel, string tag, out_t e);
    @(negedge clk);
    in_op1 = s.op1; in_op2 = s.op2; in_uses2 = s.uses2; in_mem = s.mem;
    in_rd = s.rd;   in_mc = s.mc;   in_br = s.br;
    push_exp(sel, tag, e);
    #2;
    check_now();
  endtask

  task automatic do_reset(int sel);
    rst_n = 1'b0;
    step(mk_s(0,0,0,0,0,0,0), sel, "reset", mk_e(1,1,0,0,0,0));
    rst_n = 1'b1;
  endtask

  vec_t  tab[17];
  stim_t idle, lu, mcop;
  out_t  dflt, stall_lu, stall_mc;

  initial begin
    idle     = mk_s(0,0,0,0,0,0,0);
    lu       = mk_s(5,0,0,1,5,0,0);
    mcop     = mk_s(0,0,0,0,0,1,0);

    // Main sequence on MC_CYCLES=4, CNT_W=16; outputs pw,iw,fl,bb,hd,count.
    tab[0]  = '{mk_s(0,0,0,0,0,0,0), mk_e(1,1,0,0,0,0)};  // idle
    tab[1]  = '{mk_s(5,0,0,1,5,0,0), mk_e(0,0,0,1,0,0)};  // load-use on op1
    tab[2]  = '{mk_s(0,0,0,0,0,0,0), mk_e(1,1,0,0,0,1)};  // released, +1
    tab[3]  = '{mk_s(0,0,0,1,0,0,0), mk_e(1,1,0,0,0,1)};  // rd=r0: no stall
    tab[4]  = '{mk_s(3,7,0,1,7,0,0), mk_e(1,1,0,0,0,1)};  // op2 unused: no stall
    tab[5]  = '{mk_s(3,7,1,1,7,0,0), mk_e(0,0,0,1,0,1)};  // op2 used: stall
    tab[6]  = '{mk_s(3,7,1,1,7,0,0), mk_e(1,1,0,0,0,2)};  // LDSTALL masks detect
    tab[7]  = '{mk_s(5,0,0,1,5,1,1), mk_e(1,1,1,1,0,2)};  // branch wins all
    tab[8]  = '{mk_s(0,0,0,0,0,0,0), mk_e(1,1,0,0,0,2)};  // stayed in RUN
    tab[9]  = '{mk_s(0,0,0,0,0,1,0), mk_e(0,0,0,0,1,2)};  // mc detect
    tab[10] = '{mk_s(0,0,0,0,0,1,1), mk_e(0,0,0,0,1,3)};  // MCBUSY ignores branch
    tab[11] = '{mk_s(0,0,0,0,0,1,0), mk_e(0,0,0,0,1,4)};  // MCBUSY last stall
    tab[12] = '{mk_s(0,0,0,0,0,1,0), mk_e(1,1,0,0,0,5)};  // release, 4th cycle
    tab[13] = '{mk_s(0,0,0,0,0,0,0), mk_e(1,1,0,0,0,5)};  // no count on release
    tab[14] = '{mk_s(2,0,0,1,2,0,0), mk_e(0,0,0,1,0,5)};  // load-use
    tab[15] = '{mk_s(0,0,0,0,0,1,0), mk_e(1,1,0,0,0,6)};  // LDSTALL masks mc
    tab[16] = '{mk_s(0,0,0,0,0,0,0), mk_e(1,1,0,0,0,6)};  // idle

    dflt     = mk_e(1,1,0,0,0,0);
    stall_lu = mk_e(0,0,0,1,0,0);
    stall_mc = mk_e(0,0,0,0,1,0);

    do_reset(0);
    for (int i = 0; i < 17; i++) begin
      step(tab[i].s, 0, $sformatf("vec%0d", i), tab[i].e);
    end

    // MC_CYCLES=2: only the detect cycle stalls.
    do_reset(1);
    step(idle, 1, "mc2_idle", mk_e(1,1,0,0,0,0));
    step(mcop, 1, "mc2_det",  mk_e(0,0,0,0,1,0));
    step(idle, 1, "mc2_rel",  mk_e(1,1,0,0,0,1));
    step(idle, 1, "mc2_after", mk_e(1,1,0,0,0,1));

    // Reset in the 2nd MCBUSY cycle aborts the hold asynchronously.
    do_reset(0);
    step(idle, 0, "rst_idle", mk_e(1,1,0,0,0,0));
    step(mcop, 0, "rst_det",  mk_e(0,0,0,0,1,0));
    step(mcop, 0, "rst_busy1", mk_e(0,0,0,0,1,1));
    step(idle, 0, "rst_busy2", mk_e(0,0,0,0,1,2));
    rst_n = 1'b0;
    push_exp(0, "rst_async", mk_e(1,1,0,0,0,0));
    #1;
    check_now();
    step(idle, 0, "rst_held", mk_e(1,1,0,0,0,0));
    rst_n = 1'b1;
    step(idle, 0, "rst_post1", mk_e(1,1,0,0,0,0));
    step(idle, 0, "rst_post2", mk_e(1,1,0,0,0,0));

    // CNT_W=4: 20 load-use stalls saturate at 15.
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      out_t e1, e2;
      e1 = stall_lu; e1.cnt = (i < 15) ? i : 15;
      e2 = dflt;     e2.cnt = (i + 1 < 15) ? i + 1 : 15;
      step(lu,   2, $sformatf("sat_lu%0d", i), e1);
      step(idle, 2, $sformatf("sat_rl%0d", i), e2);
    end
    step(idle, 2, "sat_final", mk_e(1,1,0,0,0,15));

    // Unused expectations would mean a lost comparison.
    chk("end", "queue_left", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
